cache_mem_responder: RTL and testbench

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

---
 rtl/cache_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_cache_mem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Memory-side responder for a write-through cache.
// Byte writes go through a small FIFO write buffer that drains into a
// 2048 x 32-bit single-port array. Line refills wait for the buffer to
// drain, read one word, and answer after a fixed latency with a one-cycle
// rvalid pulse.
module cache_mem_responder #(
  parameter int READ_LATENCY = 4,
  parameter int WBUF_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rreq_from_cache,
  input  logic [12:0] raddr_from_cache,
  input  logic        wreq_from_cache,
  input  logic [12:0] waddr_from_cache,
  input  logic [7:0]  wdata_from_cache,
  output logic [31:0] rdata_to_cache,
  output logic        rvalid_to_cache,
  output logic        wbuf_full,
  output logic        overflow_err
);

  localparam int         PTR_W    = $clog2(WBUF_DEPTH);
  localparam int         CNT_W    = PTR_W + 1;
  localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    READ_WAIT,
    RESP,
    HOLD
  } state_e;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } wentry_t;

  // Write buffer storage and bookkeeping
  wentry_t          wbuf_q [WBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  wentry_t          pop_entry;

  // Backing array and the word captured when a refill is accepted
  logic [31:0] mem_q [2048];
  logic [31:0] rd_word_q;

  // Control state
  state_e      state_q;
  logic [3:0]  lat_cnt_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic        overflow_q;

  logic wbuf_empty;
  logic pop;
  logic push;
  logic accept;

  // The two low refill address bits name a byte inside the word and are
  // deliberately ignored: a refill always returns the whole word.
  logic unused_raddr_lsb;
  assign unused_raddr_lsb = ^raddr_from_cache[1:0];

  assign wbuf_empty = (count_q == '0);
  assign wbuf_full  = (count_q == CNT_W'(WBUF_DEPTH));
  assign pop_entry  = wbuf_q[rd_ptr_q];

  // Pops happen in every state that is not holding a read in flight.
  assign pop    = !reset && !wbuf_empty &&
                  (state_q inside {IDLE, DRAIN, HOLD});
  // A full buffer still takes a write when an entry leaves in the same cycle.
  assign push   = !reset && wreq_from_cache && (!wbuf_full || pop);
  // A refill only launches once every earlier write has reached the array.
  assign accept = !reset && rreq_from_cache && wbuf_empty &&
                  (state_q inside {IDLE, DRAIN});

  // Next occupancy from this cycle's push/pop pair
  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Write buffer entries: data only, validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      wbuf_q[wr_ptr_q] <= '{addr: waddr_from_cache, data: wdata_from_cache};
    end
  end

  // Write buffer pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (wreq_from_cache && !push) overflow_q <= 1'b1;
    end
  end

  // Single-port array: a byte write on pop, or a word read on accept
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents survive reset by design.
    if (pop) begin
      mem_q[pop_entry.addr[12:2]][{pop_entry.addr[1:0], 3'b000} +: 8] <= pop_entry.data;
    end
    if (accept) begin
      rd_word_q <= mem_q[raddr_from_cache[12:2]];
    end
  end

  // Refill FSM with registered rvalid/rdata
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            lat_cnt_q <= LAT_INIT;
            state_q   <= READ_WAIT;
          end else if (rreq_from_cache && !wbuf_empty) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (accept) begin
            lat_cnt_q <= LAT_INIT;
            state_q   <= READ_WAIT;
          end else if (!rreq_from_cache) begin
            state_q <= IDLE;
          end
        end
        READ_WAIT: begin
          if (lat_cnt_q == '0) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_word_q;
            state_q  <= RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= HOLD;
        end
        HOLD: begin
          // The cache drops rreq a cycle late; wait for it to fall.
          if (!rreq_from_cache) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rdata_to_cache  = rdata_q;
  assign rvalid_to_cache = rvalid_q;
  assign overflow_err    = overflow_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: a READ_LATENCY=4 instance carries
// most scenarios, a READ_LATENCY=1 instance sharing the write/address inputs
// checks the shortest latency. Expected refill words come from a byte-lane
// memory model and travel through a scoreboard queue.
module tb_cache_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rreq_a, rreq_b;
  logic [12:0] raddr;
  logic        wreq;
  logic [12:0] waddr;
  logic [7:0]  wdata;

  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;
  logic        full_a, full_b;
  logic        ovf_a, ovf_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [int];
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  cache_mem_responder #(.READ_LATENCY(4), .WBUF_DEPTH(4)) dut_a (
    .clk              (clk),
    .reset            (reset),
    .rreq_from_cache  (rreq_a),
    .raddr_from_cache (raddr),
    .wreq_from_cache  (wreq),
    .waddr_from_cache (waddr),
    .wdata_from_cache (wdata),
    .rdata_to_cache   (rdata_a),
    .rvalid_to_cache  (rvalid_a),
    .wbuf_full        (full_a),
    .overflow_err     (ovf_a)
  );

  cache_mem_responder #(.READ_LATENCY(1), .WBUF_DEPTH(4)) dut_b (
    .clk              (clk),
    .reset            (reset),
    .rreq_from_cache  (rreq_b),
    .raddr_from_cache (raddr),
    .wreq_from_cache  (wreq),
    .waddr_from_cache (waddr),
    .wdata_from_cache (wdata),
    .rdata_to_cache   (rdata_b),
    .rvalid_to_cache  (rvalid_b),
    .wbuf_full        (full_b),
    .overflow_err     (ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [12:0] a);
    int w;
    w = int'(a[12:2]);
    if (model.exists(w)) return model[w];
    return 'x;
  endfunction

  function automatic void model_write(input logic [12:0] a, input logic [7:0] d);
    logic [31:0] t;
    t = model_word(a);
    t[{a[1:0], 3'b000} +: 8] = d;
    model[int'(a[12:2])] = t;
  endfunction

  // Advance one cycle; outputs are then sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [12:0] a, input logic [7:0] d);
    wreq  = 1'b1;
    waddr = a;
    wdata = d;
    model_write(a, d);
    tick();
    wreq = 1'b0;
  endtask

  // Full refill handshake: exp_edges counts rising edges from raising rreq
  // to the edge that starts the rvalid cycle.
  task automatic do_read(input logic [12:0] a, input int exp_edges, input bit use_b,
                         input string tag);
    int          n;
    bit          seen;
    logic [31:0] exp_word;
    sb.push_back(model_word(a));
    raddr = a;
    if (use_b) rreq_b = 1'b1; else rreq_a = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = use_b ? rvalid_b : rvalid_a;
    end
    check({tag, "_seen"}, {31'b0, seen}, 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_edges));
    exp_word = sb.pop_front();
    check({tag, "_rdata"}, use_b ? rdata_b : rdata_a, exp_word);
    tick();
    check({tag, "_single_pulse"}, {31'b0, use_b ? rvalid_b : rvalid_a}, 32'd0);
    rreq_a = 1'b0;
    rreq_b = 1'b0;
    tick();
    tick();
    check({tag, "_idle_rvalid"}, {31'b0, use_b ? rvalid_b : rvalid_a}, 32'd0);
    check({tag, "_rdata_hold"}, use_b ? rdata_b : rdata_a, exp_word);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          pulses;
    logic [31:0] exp_word;

    reset  = 1'b1;
    rreq_a = 1'b0;
    rreq_b = 1'b0;
    raddr  = '0;
    wreq   = 1'b0;
    waddr  = '0;
    wdata  = '0;
    repeat (3) tick();

    check("rst_rvalid",   {31'b0, rvalid_a}, 32'd0);
    check("rst_rdata",    rdata_a,           32'd0);
    check("rst_full",     {31'b0, full_a},   32'd0);
    check("rst_overflow", {31'b0, ovf_a},    32'd0);
    check("rst_b_rvalid", {31'b0, rvalid_b}, 32'd0);
    check("rst_b_flags",  {30'b0, full_b, ovf_b}, 32'd0);
    reset = 1'b0;
    tick();

    // Preload three words through the write path.
    for (int i = 0; i < 4; i++) begin
      do_write(13'h040 + 13'(i), 8'hAA + 8'(i * 17));
    end
    for (int i = 0; i < 4; i++) begin
      do_write(13'h080 + 13'(i), 8'h44 - 8'(i * 17));
    end
    for (int i = 0; i < 4; i++) begin
      do_write(13'h0C0 + 13'(i), 8'h01 + 8'(i));
    end
    repeat (8) tick();
    check("preload_no_overflow", {31'b0, ovf_a}, 32'd0);
    check("preload_model_word", model_word(13'h040), 32'hDDCCBBAA);

    // Basic refill; byte offset bits ignored. Acceptance on first edge.
    do_read(13'h041, 5, 1'b0, "basic");

    // Pending write forces one DRAIN pop before acceptance.
    do_write(13'h043, 8'h5A);
    do_read(13'h040, 6, 1'b0, "drain");

    // Overflow while the read is in flight; same-word writes after
    // acceptance must not show in this response.
    sb.push_back(model_word(13'h0C0));
    raddr  = 13'h0C0;
    rreq_a = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      wreq  = 1'b1;
      waddr = 13'h0C0 + 13'(i);
      wdata = 8'hA0 + 8'(i);
      model_write(waddr, wdata);
      tick();
      check($sformatf("ovf_full_%0d", i), {31'b0, full_a}, {31'b0, (i == 3)});
      check($sformatf("ovf_rvalid_%0d", i), {31'b0, rvalid_a}, {31'b0, (i == 3)});
    end
    exp_word = sb.pop_front();
    check("ovf_rdata_old_word", rdata_a, exp_word);
    check("ovf_not_yet", {31'b0, ovf_a}, 32'd0);
    waddr = 13'h100;
    wdata = 8'hEE;
    tick();
    wreq = 1'b0;
    check("ovf_set", {31'b0, ovf_a}, 32'd1);
    check("ovf_no_second_pulse", {31'b0, rvalid_a}, 32'd0);
    rreq_a = 1'b0;
    repeat (6) tick();
    check("ovf_sticky", {31'b0, ovf_a}, 32'd1);
    check("ovf_drained", {31'b0, full_a}, 32'd0);
    do_read(13'h0C0, 5, 1'b0, "late_writes");

    // Reset two cycles after acceptance abandons the read.
    raddr  = 13'h040;
    rreq_a = 1'b1;
    tick();
    tick();
    tick();
    reset  = 1'b1;
    rreq_a = 1'b0;
    tick();
    check("midrst_rvalid",   {31'b0, rvalid_a}, 32'd0);
    check("midrst_rdata",    rdata_a,           32'd0);
    check("midrst_full",     {31'b0, full_a},   32'd0);
    check("midrst_overflow", {31'b0, ovf_a},    32'd0);
    reset  = 1'b0;
    pulses = 0;
    repeat (8) begin
      tick();
      if (rvalid_a) pulses++;
    end
    check("midrst_no_late_pulse", 32'(pulses), 32'd0);
    do_read(13'h040, 5, 1'b0, "after_rst");

    // Full buffer with simultaneous push and pop in HOLD.
    sb.push_back(model_word(13'h0C0));
    raddr  = 13'h0C0;
    rreq_a = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      wreq  = 1'b1;
      waddr = 13'h140 + 13'(i);
      wdata = 8'(8'h10 * (i + 1));
      model_write(waddr, wdata);
      tick();
    end
    wreq = 1'b0;
    check("pp_rvalid", {31'b0, rvalid_a}, 32'd1);
    check("pp_full_before", {31'b0, full_a}, 32'd1);
    exp_word = sb.pop_front();
    check("pp_rdata", rdata_a, exp_word);
    tick();
    check("pp_hold_rvalid", {31'b0, rvalid_a}, 32'd0);
    wreq  = 1'b1;
    waddr = 13'h080;
    wdata = 8'h99;
    model_write(waddr, wdata);
    tick();
    wreq = 1'b0;
    check("pp_full_kept", {31'b0, full_a}, 32'd1);
    check("pp_no_overflow", {31'b0, ovf_a}, 32'd0);
    rreq_a = 1'b0;
    repeat (8) tick();
    check("pp_drained", {31'b0, full_a}, 32'd0);
    check("pp_model_0x140", model_word(13'h140), 32'h40302010);
    do_read(13'h140, 5, 1'b0, "pp_word_a");
    do_read(13'h080, 5, 1'b0, "pp_word_b");

    // Shortest latency on the second instance.
    do_read(13'h040, 2, 1'b1, "lat1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
